// File: rtl/lpc_ifilter_p_if.sv
// rtl/lpc_ifilter_p_if.sv - handshake and memory-port bundle for the LPC inverse filter
interface lpc_ifilter_p_if #(
    parameter int ORDER = 10,
    parameter int N     = 256,
    parameter int XW    = 16,
    parameter int AW    = 32
);
    localparam int KW = $clog2(ORDER + 1);
    localparam int NW = $clog2(N);

    logic          start;
    logic          ready;
    logic          done;
    logic [KW-1:0] a_rsel;
    logic [AW-1:0] a_r;
    logic [NW-1:0] x_raddr;
    logic [XW-1:0] x_r;
    logic [NW-1:0] residue_waddr;
    logic          residue_wen;
    logic [XW-1:0] residue_w;

    modport slave (
        input  start, a_r, x_r,
        output ready, done, a_rsel, x_raddr, residue_waddr, residue_wen, residue_w
    );

    modport master (
        output start, a_r, x_r,
        input  ready, done, a_rsel, x_raddr, residue_waddr, residue_wen, residue_w
    );
endinterface

// File: rtl/lpc_ifilter_p.sv
// rtl/lpc_ifilter_p.sv - LPC inverse filter producing one frame of residues (saturation option: LPC_IFILTER_SAT_EN)
module lpc_ifilter_p #(
    parameter int ORDER = 10,
    parameter int N     = 256,
    parameter int XW    = 16,
    parameter int AW    = 32,
    parameter int AFRAC = 16
) (
    input  logic           clk,
    input  logic           reset,
    lpc_ifilter_p_if.slave bus
);
    localparam int KW   = $clog2(ORDER + 1);
    localparam int NW   = $clog2(N);
    localparam int CW   = $clog2(ORDER + 3);
    localparam int PW   = XW + AW;
    localparam int ACCW = XW + AW + KW;

`ifdef LPC_IFILTER_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-XW+1){1'b1}}, {(XW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d;
    logic [CW-1:0]          c_q, c_d;
    logic [KW-1:0]          a_rsel_q, a_rsel_d;
    logic [NW-1:0]          x_raddr_q, x_raddr_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   wen_q, wen_d;
    logic [NW-1:0]          waddr_q, waddr_d;
    logic [XW-1:0]          w_q, w_d;

    logic signed [PW-1:0]   x_se, a_se, prod;
    logic signed [ACCW-1:0] prod_ext, x_ext, x_shift;
    logic                   masked;
`ifdef LPC_IFILTER_SAT_EN
    logic signed [ACCW-1:0] acc_sh;
`endif

    // Datapath terms for the tap returned this cycle; k = c-1 reaches before the frame start when k > n.
    always_comb begin
        x_se     = {{AW{bus.x_r[XW-1]}}, bus.x_r};
        a_se     = {{XW{bus.a_r[AW-1]}}, bus.a_r};
        prod     = x_se * a_se;
        prod_ext = {{KW{prod[PW-1]}}, prod};
        x_ext    = {{(ACCW-XW){bus.x_r[XW-1]}}, bus.x_r};
        x_shift  = x_ext <<< AFRAC;
        masked   = (int'(c_q) - 1) > int'(n_q);
    end

    // Next-state: frame sequencing, address issue, accumulation and residue formatting.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        c_d       = c_q;
        a_rsel_d  = a_rsel_q;
        x_raddr_d = x_raddr_q;
        acc_d     = acc_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        w_d       = w_q;
`ifdef LPC_IFILTER_SAT_EN
        acc_sh    = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_d   = S_RUN;
                    ready_d   = 1'b0;
                    n_d       = '0;
                    c_d       = '0;
                    a_rsel_d  = '0;
                    x_raddr_d = '0;
                end
            end
            S_RUN: begin
                if (c_q == CW'(1)) begin
                    acc_d = x_shift;
                end else if (c_q >= CW'(2) && c_q <= CW'(ORDER + 1) && !masked) begin
                    acc_d = acc_q - prod_ext;
                end
                if (c_q == CW'(ORDER + 1)) begin
                    wen_d   = 1'b1;
                    waddr_d = n_q;
`ifdef LPC_IFILTER_SAT_EN
                    acc_sh = acc_d >>> AFRAC;
                    if (acc_sh > SAT_MAX) begin
                        w_d = {1'b0, {(XW-1){1'b1}}};
                    end else if (acc_sh < SAT_MIN) begin
                        w_d = {1'b1, {(XW-1){1'b0}}};
                    end else begin
                        w_d = acc_sh[XW-1:0];
                    end
`else
                    w_d = acc_d[AFRAC +: XW];
`endif
                end
                if (c_q == CW'(ORDER + 2)) begin
                    c_d = '0;
                    if (n_q == NW'(N - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
                // Present the next tap's addresses one cycle ahead of its data.
                if (state_d == S_RUN && c_d <= CW'(ORDER)) begin
                    a_rsel_d  = KW'(c_d);
                    x_raddr_d = n_d - NW'(c_d);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            c_q       <= '0;
            a_rsel_q  <= '0;
            x_raddr_q <= '0;
            acc_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            w_q       <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            c_q       <= c_d;
            a_rsel_q  <= a_rsel_d;
            x_raddr_q <= x_raddr_d;
            acc_q     <= acc_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            w_q       <= w_d;
        end
    end

    assign bus.ready         = ready_q;
    assign bus.done          = done_q;
    assign bus.a_rsel        = a_rsel_q;
    assign bus.x_raddr       = x_raddr_q;
    assign bus.residue_wen   = wen_q;
    assign bus.residue_waddr = waddr_q;
    assign bus.residue_w     = w_q;
endmodule
